// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the integer pipe (0) and the
// address/branch-compare unit (1), with a registered issue stage and per-requester result slots.
module alu_issue_arbiter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [XLEN-1:0]   req0_a,
  input  logic [XLEN-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [XLEN-1:0]   req1_a,
  input  logic [XLEN-1:0]   req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [XLEN-1:0]   rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [XLEN-1:0]   rsp1_data,
  output logic              alu_issue_valid,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_result,
  output logic              busy
);

  localparam logic [CTRL_W-1:0] CtrlUnused = '1;

  logic              iss_valid_q, iss_valid_d;
  logic              iss_tag_q, iss_tag_d;
  logic              last_q, last_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [XLEN-1:0]   rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

  logic elig0, elig1, cont0, cont1, acc0, acc1, cap0, cap1;
  logic [XLEN-1:0] cap_data;

  // A requester is eligible only if it has nothing in the issue stage and its slot can take a result.
  assign elig0 = !(iss_valid_q && !iss_tag_q) && (!rsp0_valid_q || rsp0_ready);
  assign elig1 = !(iss_valid_q && iss_tag_q) && (!rsp1_valid_q || rsp1_ready);
  assign cont0 = req0_valid && elig0;
  assign cont1 = req1_valid && elig1;

  // Ready is withheld only when the other side contends and holds priority, so it never
  // depends on the requester's own valid.
  assign req0_ready = elig0 && !(cont1 && !last_q);
  assign req1_ready = elig1 && !(cont0 && last_q);
  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;

  assign cap0     = iss_valid_q && !iss_tag_q;
  assign cap1     = iss_valid_q && iss_tag_q;
  assign cap_data = (ctrl_q == CtrlUnused) ? '0 : alu_result;

  always_comb begin
    iss_valid_d  = acc0 || acc1;
    iss_tag_d    = iss_tag_q;
    last_d       = last_q;
    ctrl_d       = ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp0_valid_d = rsp0_valid_q && !rsp0_ready;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = rsp1_valid_q && !rsp1_ready;
    rsp1_data_d  = rsp1_data_q;
    if (acc0) begin
      ctrl_d    = req0_ctrl;
      a_d       = req0_a;
      b_d       = req0_b;
      iss_tag_d = 1'b0;
      last_d    = 1'b0;
    end else if (acc1) begin
      ctrl_d    = req1_ctrl;
      a_d       = req1_a;
      b_d       = req1_b;
      iss_tag_d = 1'b1;
      last_d    = 1'b1;
    end
    if (cap0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = cap_data;
    end
    if (cap1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = cap_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_q  <= 1'b0;
      iss_tag_q    <= 1'b0;
      last_q       <= 1'b1;
      ctrl_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_tag_q    <= iss_tag_d;
      last_q       <= last_d;
      ctrl_q       <= ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign alu_issue_valid = iss_valid_q;
  assign alu_ctrl        = ctrl_q;
  assign alu_a           = a_q;
  assign alu_b           = b_q;
  assign rsp0_valid      = rsp0_valid_q;
  assign rsp0_data       = rsp0_data_q;
  assign rsp1_valid      = rsp1_valid_q;
  assign rsp1_data       = rsp1_data_q;
  assign busy            = iss_valid_q || rsp0_valid_q || rsp1_valid_q;

endmodule
